// File: rtl/time_counter.sv
// BCD hours/minutes/seconds timekeeper with a RUN / SET_HR / SET_MIN set mode.
// Advances once per rising edge of the divider's 1 Hz square wave; all outputs are registered.
module time_counter #(
    parameter bit MODE_24H = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       set_hr,
    output logic       set_min,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       clk_1hz_q_r;
    logic       tick_s;
    logic [7:0] sec_inc_s;
    logic [7:0] min_inc_s;
    logic [6:0] hr_inc_s;
    logic [1:0] hr_tens_nxt_s;
    logic [3:0] hr_ones_nxt_s;
    logic [2:0] min_tens_nxt_s;
    logic [3:0] min_ones_nxt_s;
    logic [2:0] sec_tens_nxt_s;
    logic [3:0] sec_ones_nxt_s;
    logic       pm_nxt_s;
    logic       day_pulse_nxt_s;

    // Returns {carry, tens, ones} for a 00..59 BCD field incremented by one.
    function automatic logic [7:0] inc_mod60(input logic [2:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones == 4'd9) begin
            if (tens == 3'd5) begin
                r = {1'b1, 3'd0, 4'd0};
            end else begin
                r = {1'b0, tens + 3'd1, 4'd0};
            end
        end else begin
            r = {1'b0, tens, ones + 4'd1};
        end
        return r;
    endfunction

    // Returns {turn, tens, ones}; turn marks 23->00 (24h) or 11->12 (12h, flips am/pm).
    function automatic logic [6:0] inc_hours(input logic [1:0] tens, input logic [3:0] ones);
        logic [6:0] r;
        if (MODE_24H) begin
            if ((tens == 2'd2) && (ones == 4'd3)) begin
                r = {1'b1, 2'd0, 4'd0};
            end else if (ones == 4'd9) begin
                r = {1'b0, tens + 2'd1, 4'd0};
            end else begin
                r = {1'b0, tens, ones + 4'd1};
            end
        end else begin
            if ((tens == 2'd1) && (ones == 4'd1)) begin
                r = {1'b1, 2'd1, 4'd2};
            end else if ((tens == 2'd1) && (ones == 4'd2)) begin
                r = {1'b0, 2'd0, 4'd1};
            end else if (ones == 4'd9) begin
                r = {1'b0, tens + 2'd1, 4'd0};
            end else begin
                r = {1'b0, tens, ones + 4'd1};
            end
        end
        return r;
    endfunction

    // Next-state and next-time computation for all three modes.
    always_comb begin
        tick_s          = clk_1hz & ~clk_1hz_q_r;
        sec_inc_s       = inc_mod60(sec_tens, sec_ones);
        min_inc_s       = inc_mod60(min_tens, min_ones);
        hr_inc_s        = inc_hours(hr_tens, hr_ones);
        state_nxt_s     = state_r;
        hr_tens_nxt_s   = hr_tens;
        hr_ones_nxt_s   = hr_ones;
        min_tens_nxt_s  = min_tens;
        min_ones_nxt_s  = min_ones;
        sec_tens_nxt_s  = sec_tens;
        sec_ones_nxt_s  = sec_ones;
        pm_nxt_s        = pm;
        day_pulse_nxt_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mode_btn) begin
                    state_nxt_s = SET_HR;
                end else begin
                    state_nxt_s = RUN;
                end
                if (tick_s) begin
                    {sec_tens_nxt_s, sec_ones_nxt_s} = sec_inc_s[6:0];
                    if (sec_inc_s[7]) begin
                        {min_tens_nxt_s, min_ones_nxt_s} = min_inc_s[6:0];
                        if (min_inc_s[7]) begin
                            {hr_tens_nxt_s, hr_ones_nxt_s} = hr_inc_s[5:0];
                            pm_nxt_s        = MODE_24H ? 1'b0 : (pm ^ hr_inc_s[6]);
                            // In 12h mode the day only ends when the turn happens from PM.
                            day_pulse_nxt_s = hr_inc_s[6] & (MODE_24H | pm);
                        end else begin
                            day_pulse_nxt_s = 1'b0;
                        end
                    end else begin
                        day_pulse_nxt_s = 1'b0;
                    end
                end else begin
                    day_pulse_nxt_s = 1'b0;
                end
            end
            SET_HR: begin
                if (mode_btn) begin
                    state_nxt_s = SET_MIN;
                end else if (inc_btn) begin
                    {hr_tens_nxt_s, hr_ones_nxt_s} = hr_inc_s[5:0];
                    pm_nxt_s = MODE_24H ? 1'b0 : (pm ^ hr_inc_s[6]);
                end else begin
                    state_nxt_s = SET_HR;
                end
            end
            SET_MIN: begin
                if (mode_btn) begin
                    state_nxt_s    = RUN;
                    sec_tens_nxt_s = 3'd0;
                    sec_ones_nxt_s = 4'd0;
                end else if (inc_btn) begin
                    {min_tens_nxt_s, min_ones_nxt_s} = min_inc_s[6:0];
                end else begin
                    state_nxt_s = SET_MIN;
                end
            end
            default: begin
                state_nxt_s = RUN;
            end
        endcase
    end

    // State, time digits and status flags, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= RUN;
            clk_1hz_q_r <= 1'b0;
            hr_tens     <= MODE_24H ? 2'd0 : 2'd1;
            hr_ones     <= MODE_24H ? 4'd0 : 4'd2;
            min_tens    <= 3'd0;
            min_ones    <= 4'd0;
            sec_tens    <= 3'd0;
            sec_ones    <= 4'd0;
            pm          <= 1'b0;
            set_hr      <= 1'b0;
            set_min     <= 1'b0;
            day_pulse   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clk_1hz_q_r <= clk_1hz;
            hr_tens     <= hr_tens_nxt_s;
            hr_ones     <= hr_ones_nxt_s;
            min_tens    <= min_tens_nxt_s;
            min_ones    <= min_ones_nxt_s;
            sec_tens    <= sec_tens_nxt_s;
            sec_ones    <= sec_ones_nxt_s;
            pm          <= pm_nxt_s;
            set_hr      <= (state_nxt_s == SET_HR);
            set_min     <= (state_nxt_s == SET_MIN);
            day_pulse   <= day_pulse_nxt_s;
        end
    end

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter: a 24h and a 12h instance share one set of stimulus inputs.
module tb_time_counter;

    logic       clk;
    logic       rst;
    logic       clk_1hz;
    logic       mode_btn;
    logic       inc_btn;

    logic [1:0] a_hr_tens, b_hr_tens;
    logic [3:0] a_hr_ones, b_hr_ones;
    logic [2:0] a_min_tens, b_min_tens;
    logic [3:0] a_min_ones, b_min_ones;
    logic [2:0] a_sec_tens, b_sec_tens;
    logic [3:0] a_sec_ones, b_sec_ones;
    logic       a_pm, b_pm;
    logic       a_set_hr, b_set_hr;
    logic       a_set_min, b_set_min;
    logic       a_day_pulse, b_day_pulse;

    int checks = 0;
    int errors = 0;

    time_counter #(.MODE_24H(1'b1)) dut24 (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hr_tens(a_hr_tens), .hr_ones(a_hr_ones), .min_tens(a_min_tens), .min_ones(a_min_ones),
        .sec_tens(a_sec_tens), .sec_ones(a_sec_ones), .pm(a_pm), .set_hr(a_set_hr),
        .set_min(a_set_min), .day_pulse(a_day_pulse)
    );

    time_counter #(.MODE_24H(1'b0)) dut12 (
        .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hr_tens(b_hr_tens), .hr_ones(b_hr_ones), .min_tens(b_min_tens), .min_ones(b_min_ones),
        .sec_tens(b_sec_tens), .sec_ones(b_sec_ones), .pm(b_pm), .set_hr(b_set_hr),
        .set_min(b_set_min), .day_pulse(b_day_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int t24();
        return a_hr_tens * 100000 + a_hr_ones * 10000 + a_min_tens * 1000 +
               a_min_ones * 100 + a_sec_tens * 10 + a_sec_ones;
    endfunction

    function automatic int t12();
        return b_hr_tens * 100000 + b_hr_ones * 10000 + b_min_tens * 1000 +
               b_min_ones * 100 + b_sec_tens * 10 + b_sec_ones;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_mode();
        @(negedge clk); mode_btn = 1'b1;
        @(negedge clk); mode_btn = 1'b0;
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); inc_btn = 1'b1;
            @(negedge clk); inc_btn = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); clk_1hz = 1'b1;
            @(negedge clk); clk_1hz = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; clk_1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;

        // 1: reset state
        do_reset();
        check("rst_time24", t24(), 0);
        check("rst_set_hr", a_set_hr, 0);
        check("rst_set_min", a_set_min, 0);
        check("rst_day_pulse", a_day_pulse, 0);
        check("rst_time12", t12(), 120000);
        check("rst_pm12", b_pm, 0);

        // 2: set 23:59, run to midnight (12h instance lands on 11:59:59 PM)
        pulse_mode();
        check("enter_set_hr", a_set_hr, 1);
        pulse_inc(23);
        check("set_hr_23", t24(), 230000);
        pulse_mode();
        check("enter_set_min", a_set_min, 1);
        pulse_inc(59);
        pulse_mode();
        check("exit_set", t24(), 235900);
        check("exit_flags", {a_set_hr, a_set_min}, 0);
        ticks(59);
        check("t24_235959", t24(), 235959);
        check("t12_115959", t12(), 115959);
        check("t12_pm_before", b_pm, 1);
        ticks(1);
        check("midnight24", t24(), 0);
        check("day_pulse24_hi", a_day_pulse, 1);
        check("midnight12", t12(), 120000);
        check("pm12_after", b_pm, 0);
        check("day_pulse12_hi", b_day_pulse, 1);
        @(negedge clk);
        check("day_pulse24_lo", a_day_pulse, 0);
        check("day_pulse12_lo", b_day_pulse, 0);

        // 3: a held-high 1 Hz level advances only once per rising edge
        for (int i = 0; i < 3; i++) begin
            clk_1hz = 1'b1;
            repeat (10) @(negedge clk);
            clk_1hz = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("held_level", t24(), 3);
        pulse_inc(1);
        check("inc_in_run", t24(), 3);

        // 4: hour wrap in SET_HR with ticks running, then simultaneous-input cases
        pulse_mode();
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); inc_btn = 1'b1; clk_1hz = 1'b1;
            @(negedge clk); inc_btn = 1'b0; clk_1hz = 1'b0;
        end
        check("set_hr_wrap", t24(), 10003);
        @(negedge clk); mode_btn = 1'b1; inc_btn = 1'b1;
        @(negedge clk); mode_btn = 1'b0; inc_btn = 1'b0;
        check("mode_inc_state", {a_set_hr, a_set_min}, 1);
        check("mode_inc_time", t24(), 10003);
        @(negedge clk); mode_btn = 1'b1; clk_1hz = 1'b1;
        @(negedge clk); mode_btn = 1'b0; clk_1hz = 1'b0;
        check("setmin_exit_tick", t24(), 10000);
        check("setmin_exit_flag", a_set_min, 0);
        @(negedge clk); mode_btn = 1'b1; clk_1hz = 1'b1;
        @(negedge clk); mode_btn = 1'b0; clk_1hz = 1'b0;
        check("run_mode_tick", t24(), 10001);
        check("run_mode_state", a_set_hr, 1);
        pulse_mode();
        pulse_mode();
        check("run_again", t24(), 10000);

        // 5: 12h noon turn (AM->PM, no day pulse) and 12:59:59 -> 01:00:00
        do_reset();
        pulse_mode();
        pulse_inc(11);
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        ticks(59);
        check("t12_am_115959", t12(), 115959);
        check("t12_am_pm", b_pm, 0);
        ticks(1);
        check("noon_time", t12(), 120000);
        check("noon_pm", b_pm, 1);
        check("noon_no_day", b_day_pulse, 0);
        pulse_mode();
        pulse_mode();
        pulse_inc(59);
        pulse_mode();
        ticks(59);
        check("t12_125959", t12(), 125959);
        ticks(1);
        check("t12_one_pm", t12(), 10000);
        check("t12_one_pm_flag", b_pm, 1);

        // 6: reset in the middle of SET_MIN
        do_reset();
        pulse_mode();
        pulse_inc(10);
        pulse_mode();
        pulse_inc(20);
        pulse_mode();
        ticks(35);
        check("t24_102035", t24(), 102035);
        pulse_mode();
        pulse_mode();
        check("mid_set_min", a_set_min, 1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_time", t24(), 0);
        check("mid_rst_flags", {a_set_hr, a_set_min}, 0);
        ticks(1);
        check("mid_rst_run", t24(), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
